vedic_8by4_divider: RTL and testbench



---
 rtl/vedic_div_pkg.sv | 12 +
 rtl/div_step.sv | 21 ++
 rtl/vedic_8by4_divider.sv | 117 +++++++++++
 tb/tb_vedic_8by4_divider.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/vedic_div_pkg.sv
// vedic_div_pkg: shared widths and FSM state encoding for the 8-by-4 restoring divider
package vedic_div_pkg;
    localparam int DIV_DW  = 8;
    localparam int DIV_VW  = 4;
    localparam int STEP_CW = $clog2(DIV_DW);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step (shift in a dividend bit, trial-subtract, keep or restore)
module div_step #(
    parameter int VW = 4
) (
    input  logic [VW-1:0] i_rem,
    input  logic          i_bit,
    input  logic [VW-1:0] i_div,
    output logic [VW-1:0] o_rem,
    output logic          o_q
);
    logic [VW:0]   w_sh;
    logic [VW-1:0] w_diff;

    // A successful trial leaves a result below the divisor, so the low VW bits of the difference are exact
    always_comb begin
        w_sh   = {i_rem, i_bit};
        w_diff = w_sh[VW-1:0] - i_div;
        o_q    = w_sh >= {1'b0, i_div};
        o_rem  = o_q ? w_diff : w_sh[VW-1:0];
    end
endmodule

// File: rtl/vedic_8by4_divider.sv
// vedic_8by4_divider: sequential restoring divider, one quotient bit per clock; macro DIV_ZERO_DETECT_EN enables the 1-cycle divide-by-zero shortcut
module vedic_8by4_divider
    import vedic_div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [DW-1:0] i_dividend,
    input  logic [VW-1:0] i_divisor,
    output logic          o_busy,
    output logic          o_done,
    output logic [DW-1:0] o_quotient,
    output logic [VW-1:0] o_remainder,
    output logic          o_div_zero
);
    div_state_t         r_state;
    logic [STEP_CW-1:0] r_cnt;
    logic [DW-1:0]      r_dvd;
    logic [VW-1:0]      r_dvs;
    logic [VW-1:0]      r_rem;
    logic               r_busy;
    logic               r_done;
    logic [DW-1:0]      r_quo;
    logic [VW-1:0]      r_rmd;
    logic [VW-1:0]      w_rem;
    logic               w_q;

    div_step #(.VW(VW)) u_step (
        .i_rem (r_rem),
        .i_bit (r_dvd[DW-1]),
        .i_div (r_dvs),
        .o_rem (w_rem),
        .o_q   (w_q)
    );

`ifdef DIV_ZERO_DETECT_EN
    logic r_dz;

    // Divide-by-zero flag tracks the most recent result only
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_dz <= 1'b0;
        else if (r_state != RUN && i_start)
            r_dz <= (i_divisor == '0) ? 1'b1 : r_dz;
        else if (r_state == RUN && r_cnt == STEP_CW'(DW-1))
            r_dz <= 1'b0;
    end

    assign o_div_zero = r_dz;
`else
    assign o_div_zero = 1'b0;
`endif

    // Control FSM and datapath: r_dvd shifts dividend bits out the top while quotient bits enter the bottom
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quo   <= '0;
            r_rmd   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_dvd <= i_dividend;
                        r_dvs <= i_divisor;
                        r_rem <= '0;
                        r_cnt <= '0;
`ifdef DIV_ZERO_DETECT_EN
                        if (i_divisor == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_quo   <= '1;
                            r_rmd   <= i_dividend[VW-1:0];
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
`else
                        r_state <= RUN;
                        r_busy  <= 1'b1;
`endif
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_dvd <= {r_dvd[DW-2:0], w_q};
                    r_rem <= w_rem;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == STEP_CW'(DW-1)) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_quo   <= {r_dvd[DW-2:0], w_q};
                        r_rmd   <= w_rem;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_quotient  = r_quo;
    assign o_remainder = r_rmd;
endmodule

// File: tb/tb_vedic_8by4_divider.sv
// tb_vedic_8by4_divider: directed and sweep checks of the 8-by-4 restoring divider
module tb_vedic_8by4_divider;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] i_dividend = '0;
    logic [3:0] i_divisor = '0;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_quotient;
    logic [3:0] o_remainder;
    logic       o_div_zero;
    int         n_chk = 0;
    int         n_err = 0;
    int         lat;
    int         bcnt;

`ifdef DIV_ZERO_DETECT_EN
    localparam int ZLAT = 0;
    localparam logic ZFLAG = 1'b1;
`else
    localparam int ZLAT = 8;
    localparam logic ZFLAG = 1'b0;
`endif

    vedic_8by4_divider dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder),
        .o_div_zero  (o_div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counts edges after acceptance until done (lat) and busy samples meanwhile
    task automatic wait_done(output int l, output int b);
        l = 0;
        b = 0;
        while (!o_done && l < 20) begin
            if (o_busy) b++;
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic op(input logic [7:0] a, input logic [3:0] d, output int l, output int b);
        @(negedge clk);
        i_start = 1'b1;
        i_dividend = a;
        i_divisor = d;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_done(l, b);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_q", o_quotient, 0);
        chk("rst_r", o_remainder, 0);
        chk("rst_dz", o_div_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        op(8'd200, 4'd7, lat, bcnt);
        chk("200_7_lat", lat, 8);
        chk("200_7_busy", bcnt, 8);
        chk("200_7_q", o_quotient, 28);
        chk("200_7_r", o_remainder, 4);
        chk("200_7_dz", o_div_zero, 0);

        @(negedge clk);
        i_start = 1'b1;
        i_dividend = 8'd225;
        i_divisor = 4'd15;
        @(posedge clk);
        #1;
        i_dividend = 8'd255;
        i_divisor = 4'd1;
        wait_done(lat, bcnt);
        chk("b2b1_lat", lat, 8);
        chk("b2b1_q", o_quotient, 15);
        chk("b2b1_r", o_remainder, 0);
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_done(lat, bcnt);
        chk("b2b_gap", lat + 1, 9);
        chk("b2b2_q", o_quotient, 255);
        chk("b2b2_r", o_remainder, 0);

        @(negedge clk);
        i_start = 1'b1;
        i_dividend = 8'd5;
        i_divisor = 4'd9;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_start = 1'b1;
        i_dividend = 8'd200;
        i_divisor = 4'd3;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        wait_done(lat, bcnt);
        chk("5_9_lat", lat + 4, 8);
        chk("5_9_q", o_quotient, 0);
        chk("5_9_r", o_remainder, 5);
        @(posedge clk);
        #1;
        chk("5_9_nodone", o_done, 0);
        chk("5_9_idle", o_busy, 0);

        op(8'hA7, 4'd0, lat, bcnt);
        chk("z_lat", lat, ZLAT);
        chk("z_q", o_quotient, 8'hFF);
        chk("z_r", o_remainder, 4'h7);
        chk("z_dz", o_div_zero, ZFLAG);

        @(negedge clk);
        i_start = 1'b1;
        i_dividend = 8'd200;
        i_divisor = 4'd7;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", o_busy, 0);
        chk("arst_done", o_done, 0);
        chk("arst_q", o_quotient, 0);
        chk("arst_r", o_remainder, 0);
        chk("arst_dz", o_div_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        op(8'd96, 4'd12, lat, bcnt);
        chk("96_12_lat", lat, 8);
        chk("96_12_q", o_quotient, 8);
        chk("96_12_r", o_remainder, 0);

        for (int a = 0; a < 256; a++) begin
            for (int d = 1; d < 16; d++) begin
                op(8'(a), 4'(d), lat, bcnt);
                chk("sw_lat", lat, 8);
                chk("sw_q", o_quotient, a / d);
                chk("sw_recon", o_quotient * d + o_remainder, a);
                chk("sw_rlt", o_remainder < d, 1);
                chk("sw_dz", o_div_zero, 0);
                if (a % d == 0 && a / d < 16) chk("sw_mul", (a / d) * d, o_quotient * d);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
